// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_reg.sv
// WIDTH-bit bidirectional shift register with synchronous parallel load.
// Load has priority over shift. Both end bits are exposed so the controller
// can pick the departing bit without knowing the register layout.
module shift_seq_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ins,
  output logic [WIDTH-1:0] data,
  output logic             lsb,
  output logic             msb
);

  // Register update: load, else shift toward the selected end inserting ins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) data <= {ins, data[WIDTH-1:1]};
      else                  data <= {data[WIDTH-2:0], ins};
    end
  end

  assign lsb = data[0];
  assign msb = data[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a parallel-load / N-shift / present transfer on a WIDTH-bit
// shift register. Optional feature macro: SHIFT_SEQ_ROTATE_EN adds a rotate
// input; when latched high the departing bit is re-inserted instead of ser_in.
//
// state | meaning
// IDLE  | waiting for start, register holds last result
// SHIFT | one shift per edge, ser_out/ser_valid presented
// DONE  | one-cycle done pulse, par_out holds final contents
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             ser_in,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rotate,
`endif
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [WIDTH-1:0] par_out
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_clamped;
  logic             dir_q;
  logic             load;
  logic             shift_en;
  logic             out_bit;
  logic             ins_bit;
  logic             lsb;
  logic             msb;

  assign cnt_clamped = (shift_count > MAX_CNT) ? MAX_CNT : shift_count;
  assign load        = (state == IDLE) && start;
  assign shift_en    = (state == SHIFT);
  assign out_bit     = (dir_q == DIR_RIGHT) ? lsb : msb;
  assign ser_out     = ser_valid & out_bit;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q;

  // Rotate mode is latched with the command like dir.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rot_q <= 1'b0;
    else if (load) rot_q <= rotate;
  end

  assign ins_bit = rot_q ? out_bit : ser_in;
`else
  assign ins_bit = ser_in;
`endif

  shift_seq_reg #(.WIDTH(WIDTH)) u_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift_en  (shift_en),
    .dir       (dir_q),
    .ins       (ins_bit),
    .data      (par_out),
    .lsb       (lsb),
    .msb       (msb)
  );

  // Transfer FSM with shift counter; busy/ser_valid/done registered with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_q     <= DIR_LEFT;
      busy      <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q <= dir;
            cnt   <= cnt_clamped;
            busy  <= 1'b1;
            if (cnt_clamped != '0) begin
              state     <= SHIFT;
              ser_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            ser_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller that sequences a WIDTH-bit bidirectional shift register through a complete serial transfer. It parallel-loads a word, performs a programmed number of left or right shifts while streaming out the departing bit and inserting a serial-in bit, then presents the final register contents. It sits between a requester issuing transfer commands and the serial link or other shift-register datapath.

## Interface
- WIDTH, 4, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of the shift-count field

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command request; accepted only when busy=0
- dir  input  1  1 = shift right (toward bit 0), 0 = shift left (toward bit WIDTH-1); sampled with start
- load_data  input  WIDTH  parallel word loaded on accept
- shift_count  input  CNT_W  number of shifts; sampled with start
- ser_in  input  1  bit inserted at the vacated end on each shift
- busy  output  1  transfer in progress
- ser_out  output  1  bit leaving the register this cycle
- ser_valid  output  1  ser_out is meaningful; one shift occurs at the next edge
- done  output  1  one-cycle completion pulse
- par_out  output  WIDTH  register contents; valid when done=1

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. On edge with start=1: reg←load_data, dir latched, cnt←min(shift_count, WIDTH); next state SHIFT if the clamped count ≠0, else DONE.
- SHIFT: busy=1, ser_valid=1. ser_out = reg[0] (right) or reg[WIDTH-1] (left). At each edge: right: reg←{in, reg[WIDTH-1:1]}; left: reg←{reg[WIDTH-2:0], in}; in = ser_in; cnt←cnt−1. When cnt=1 at the edge, the next state is DONE.
- DONE: busy=1, done=1, par_out=reg; next edge → IDLE.
- start is ignored while busy=1 (no queuing). dir, load_data, shift_count, and ser_in are don't-care outside their sampling edges.
- ser_out=0 whenever ser_valid=0. par_out always reflects reg; it is guaranteed only with done=1.
- Counts above WIDTH are clamped to WIDTH. The register is never shifted more than WIDTH times per command.

## Timing
- Reset (asynchronous, immediate): state=IDLE; reg=0, cnt=0; busy=0, ser_valid=0, ser_out=0, done=0, par_out=0.
- Reset asserted mid-transfer aborts the transfer immediately. No done pulse is produced. After release, the block waits in IDLE for a new start.
- Accept edge E0; with clamped count N≥1: ser_valid high in cycles E0+1..E0+N; done in cycle E0+N+1; IDLE at E0+N+2. Earliest next accept is edge E0+N+2.
- N=0: done in cycle E0+1.
- busy rises in the cycle after E0 and falls in the cycle after done.
- Consumer samples ser_out and the requester drives ser_in on the same edge as the shift.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined: adds input port rotate (1 bit), sampled with start. When the latched rotate=1, the inserted bit is the outgoing bit and ser_in is ignored. When rotate=0, behaviour is identical to the macro-undefined build.
- Undefined: no rotate port; the inserted bit is always ser_in.

## Structure
- Package shift_seq_pkg: state enum (IDLE, SHIFT, DONE), DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
- Sub-module shift_seq_reg: WIDTH-bit register with synchronous load, shift enable, direction, and serial-in. It exposes its contents and both end bits. The controller FSM, counter, and clamp logic live in shift_sequencer.

## Test plan
- WIDTH=4, right shift, load 4'b1011, count 4, ser_in=0 → ser_out sequence 1,1,0,1 on four ser_valid cycles; done with par_out=4'b0000.
- Left shift, load 4'b1011, count 2, ser_in=1 → ser_out 1,0; done with par_out=4'b1111.
- Count 0, load 4'b0110 → no ser_valid; done in cycle E0+1 with par_out=4'b0110. Count 7 → exactly 4 ser_valid cycles.
- start held high continuously → commands accepted only at E0 and E0+N+2; start during busy has no effect.
- rst pulsed during the 2nd shift → all outputs 0 immediately, no done; a new command after release completes normally.
- SHIFT_SEQ_ROTATE_EN: right shift, rotate=1, load 4'b1001, count 1 → ser_out 1; par_out=4'b1100.
